// File: rtl/flag_ctx_pkg.sv
// Shared types for the C/Z flag context sequencer: FSM states, the saved flag pair
// and the bit positions in the sticky ERR vector.
package flag_ctx_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SAVE    = 2'd1,
        VECTOR  = 2'd2,
        RESTORE = 2'd3
    } ctx_state_t;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UFL_BIT = 1;

endpackage

// File: rtl/flag_ctx_ctrl_if.sv
// Core-side bundle of the flag context sequencer. The master is the control unit /
// ALU / interrupt source; the slave is flag_ctx_ctrl.
interface flag_ctx_ctrl_if #(
    parameter int CNT_W = 1
);
    import flag_ctx_pkg::*;

    // SEI, CLI, RETI and FLG_LD are single-cycle strobes that are acted on only while
    // STALL is low; while STALL is high the core holds and any strobe is dropped.
    logic             INTR;
    logic             SEI;
    logic             CLI;
    logic             RETI;
    logic             BOUNDARY;
    logic             FLG_LD;
    logic             C_IN;
    logic             Z_IN;
    logic             C_FLAG;
    logic             Z_FLAG;
    logic             IE;
    logic             STALL;
    logic             INT_TAKEN;
    logic [CNT_W-1:0] DEPTH_CNT;
    logic [1:0]       ERR;
    ctx_state_t       DBG_STATE;

    modport master (
        output INTR, SEI, CLI, RETI, BOUNDARY, FLG_LD, C_IN, Z_IN,
        input  C_FLAG, Z_FLAG, IE, STALL, INT_TAKEN, DEPTH_CNT, ERR, DBG_STATE
    );

    modport slave (
        input  INTR, SEI, CLI, RETI, BOUNDARY, FLG_LD, C_IN, Z_IN,
        output C_FLAG, Z_FLAG, IE, STALL, INT_TAKEN, DEPTH_CNT, ERR, DBG_STATE
    );

endinterface

// File: rtl/flag_ctx_stack.sv
// LIFO shadow store for saved C/Z pairs. The count saturates at DEPTH and floors
// at 0; top_data always shows the most recently pushed entry.
module flag_ctx_stack
    import flag_ctx_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  flags_t           push_data,
    output flags_t           top_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    flags_t mem [DEPTH];
    logic   do_push;
    logic   do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~push;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CNT_W'(1);
        end else if (do_pop) begin
            count <= count - CNT_W'(1);
        end
    end

    // Contents need no reset: an entry is only ever read after it was pushed.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && count == CNT_W'(i)) begin
                mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CNT_W'(i + 1)) begin
                top_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/flag_ctx_ctrl.sv
// Interrupt-entry / RETI sequencer owning the live C/Z flags and IE.
// Define FLAG_CTX_ERR_EN to build the sticky {underflow, overflow} ERR bits.
module flag_ctx_ctrl
    import flag_ctx_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    flag_ctx_ctrl_if.slave bus
);

    ctx_state_t       state;
    ctx_state_t       state_nxt;
    logic             intr_q;
    logic             intr_rise;
    logic             pending;
    logic             ie;
    logic             qualify;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    flags_t           live;
    flags_t           top;

    assign intr_rise = bus.INTR & ~intr_q;
    assign qualify   = pending & ie & bus.BOUNDARY;

    flag_ctx_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_stack (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .pop       (pop),
        .push_data (live),
        .top_data  (top),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // RETI wins over a simultaneous entry; a full store withholds entry and leaves pending set.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (bus.RETI) begin
                    state_nxt = RESTORE;
                end else if (qualify && !full) begin
                    state_nxt = SAVE;
                end
            end
            SAVE:    state_nxt = VECTOR;
            VECTOR:  state_nxt = RUN;
            RESTORE: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        bus.STALL     = 1'b1;
        bus.INT_TAKEN = 1'b0;
        case (state)
            RUN:     bus.STALL     = 1'b0;
            SAVE:    push          = 1'b1;
            VECTOR:  bus.INT_TAKEN = 1'b1;
            RESTORE: pop           = 1'b1;
            default: ;
        endcase
    end

    // A fresh INTR edge outranks the VECTOR-cycle clear so back-to-back requests survive.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            intr_q  <= 1'b0;
            pending <= 1'b0;
            ie      <= 1'b0;
            live    <= '0;
        end else begin
            intr_q <= bus.INTR;
            if (intr_rise) begin
                pending <= 1'b1;
            end else if (state == VECTOR) begin
                pending <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (bus.FLG_LD) begin
                        live <= {bus.C_IN, bus.Z_IN};
                    end
                    if (bus.CLI) begin
                        ie <= 1'b0;
                    end else if (bus.SEI) begin
                        ie <= 1'b1;
                    end
                end
                SAVE: ie <= 1'b0;
                RESTORE: begin
                    ie <= 1'b1;
                    if (!empty) begin
                        live <= top;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FLAG_CTX_ERR_EN
    logic [1:0] err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 2'b00;
        end else begin
            if (state == RUN && !bus.RETI && qualify && full) begin
                err[ERR_OVF_BIT] <= 1'b1;
            end
            if (state == RESTORE && empty) begin
                err[ERR_UFL_BIT] <= 1'b1;
            end
        end
    end

    assign bus.ERR = err;
`else
    assign bus.ERR = 2'b00;
`endif

    assign bus.C_FLAG    = live.c;
    assign bus.Z_FLAG    = live.z;
    assign bus.IE        = ie;
    assign bus.DEPTH_CNT = count;
    assign bus.DBG_STATE = state;

endmodule

// File: tb/tb_flag_ctx_ctrl.sv
// Bench for flag_ctx_ctrl (DEPTH=2): directed scenarios with literal expectations,
// then randomized stimulus, all checked each cycle against a behavioural model.
module tb_flag_ctx_ctrl;
    import flag_ctx_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FLAG_CTX_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    flag_ctx_ctrl_if #(.CNT_W(CNT_W)) bus ();

    flag_ctx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // entry_left counts the remaining stall cycles of an interrupt entry (2 = saving,
    // 1 = vectoring); restore_now marks the single stall cycle of a RETI.
    logic       m_c, m_z, m_ie, m_pend, m_intr_prev, m_rise, m_ie_old;
    logic [1:0] m_err;
    logic [1:0] shadow_q[$];
    int         entry_left;
    bit         restore_now;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_c = 1'b0; m_z = 1'b0; m_ie = 1'b0; m_pend = 1'b0; m_intr_prev = 1'b0;
            m_err = 2'b00; entry_left = 0; restore_now = 1'b0;
            shadow_q.delete();
        end else begin
            m_rise = bus.INTR && !m_intr_prev;
            m_intr_prev = bus.INTR;
            if (restore_now) begin
                if (shadow_q.size() > 0) {m_c, m_z} = shadow_q.pop_back();
                else m_err[1] = 1'b1;
                m_ie = 1'b1;
                restore_now = 1'b0;
            end else if (entry_left == 2) begin
                shadow_q.push_back({m_c, m_z});
                m_ie = 1'b0;
                entry_left = 1;
            end else if (entry_left == 1) begin
                m_pend = 1'b0;
                entry_left = 0;
            end else begin
                m_ie_old = m_ie;
                if (bus.FLG_LD) begin
                    m_c = bus.C_IN;
                    m_z = bus.Z_IN;
                end
                if (bus.CLI) m_ie = 1'b0;
                else if (bus.SEI) m_ie = 1'b1;
                if (bus.RETI) restore_now = 1'b1;
                else if (m_pend && m_ie_old && bus.BOUNDARY) begin
                    if (shadow_q.size() < DEPTH) entry_left = 2;
                    else m_err[0] = 1'b1;
                end
            end
            if (m_rise) m_pend = 1'b1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("c_flag",    32'(bus.C_FLAG),    32'(m_c));
            check("z_flag",    32'(bus.Z_FLAG),    32'(m_z));
            check("ie",        32'(bus.IE),        32'(m_ie));
            check("stall",     32'(bus.STALL),     32'(entry_left != 0 || restore_now));
            check("int_taken", 32'(bus.INT_TAKEN), 32'(entry_left == 1));
            check("depth_cnt", 32'(bus.DEPTH_CNT), 32'(shadow_q.size()));
            check("err",       32'(bus.ERR),       32'(ERR_EN ? m_err : 2'b00));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        bus.SEI = 1'b0; bus.CLI = 1'b0; bus.RETI = 1'b0; bus.FLG_LD = 1'b0;
    endtask

    task automatic load_flags(input logic c, input logic z);
        bus.FLG_LD = 1'b1; bus.C_IN = c; bus.Z_IN = z;
        tick();
    endtask

    task automatic do_sei();
        bus.SEI = 1'b1;
        tick();
    endtask

    task automatic do_reti();
        bus.RETI = 1'b1;
        tick();
        tick();
    endtask

    // Assumes IE=1 and BOUNDARY=1; checks the 2-cycle entry latency.
    task automatic take_int();
        bus.INTR = 1'b0;
        tick();
        bus.INTR = 1'b1;
        tick();
        check("qual_stall", 32'(bus.STALL), 32'd0);
        tick();
        check("save_stall", 32'(bus.STALL), 32'd1);
        check("save_taken", 32'(bus.INT_TAKEN), 32'd0);
        tick();
        check("vec_taken", 32'(bus.INT_TAKEN), 32'd1);
        check("vec_ie", 32'(bus.IE), 32'd0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        bus.INTR = 1'b0; bus.SEI = 1'b0; bus.CLI = 1'b0; bus.RETI = 1'b0;
        bus.BOUNDARY = 1'b0; bus.FLG_LD = 1'b0; bus.C_IN = 1'b0; bus.Z_IN = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_c", 32'(bus.C_FLAG), 32'd0);
        check("rst_z", 32'(bus.Z_FLAG), 32'd0);
        check("rst_ie", 32'(bus.IE), 32'd0);
        check("rst_stall", 32'(bus.STALL), 32'd0);
        check("rst_taken", 32'(bus.INT_TAKEN), 32'd0);
        check("rst_depth", 32'(bus.DEPTH_CNT), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        RST = 1'b0;
        bus.BOUNDARY = 1'b1;

        // basic save / restore
        load_flags(1'b1, 1'b0);
        do_sei();
        take_int();
        check("basic_depth", 32'(bus.DEPTH_CNT), 32'd1);
        load_flags(1'b0, 1'b1);
        do_reti();
        check("basic_c", 32'(bus.C_FLAG), 32'd1);
        check("basic_z", 32'(bus.Z_FLAG), 32'd0);
        check("basic_ie", 32'(bus.IE), 32'd1);
        check("basic_depth0", 32'(bus.DEPTH_CNT), 32'd0);

        // nesting to full, then overflow attempt
        load_flags(1'b0, 1'b1);
        take_int();
        do_sei();
        load_flags(1'b1, 1'b0);
        take_int();
        check("nest_depth2", 32'(bus.DEPTH_CNT), 32'd2);
        do_sei();
        bus.INTR = 1'b0;
        tick();
        bus.INTR = 1'b1;
        repeat (4) tick();
        check("ovf_stall", 32'(bus.STALL), 32'd0);
        check("ovf_depth", 32'(bus.DEPTH_CNT), 32'd2);
        check("ovf_err0", 32'(bus.ERR[0]), 32'(ERR_EN));
        load_flags(1'b0, 1'b0);
        bus.BOUNDARY = 1'b0;
        do_reti();
        check("pop1_c", 32'(bus.C_FLAG), 32'd1);
        check("pop1_z", 32'(bus.Z_FLAG), 32'd0);
        check("pop1_depth", 32'(bus.DEPTH_CNT), 32'd1);
        do_reti();
        check("pop2_c", 32'(bus.C_FLAG), 32'd0);
        check("pop2_z", 32'(bus.Z_FLAG), 32'd1);
        check("pop2_depth", 32'(bus.DEPTH_CNT), 32'd0);

        // held pending, gated by BOUNDARY, enters once BOUNDARY rises
        repeat (2) tick();
        check("bnd_gate_stall", 32'(bus.STALL), 32'd0);
        bus.BOUNDARY = 1'b1;
        tick();
        check("bnd_save", 32'(bus.STALL), 32'd1);
        tick();
        check("bnd_taken", 32'(bus.INT_TAKEN), 32'd1);
        tick();

        // RETI and a qualifying interrupt in the same cycle
        do_sei();
        bus.BOUNDARY = 1'b0;
        bus.INTR = 1'b0;
        tick();
        bus.INTR = 1'b1;
        tick();
        bus.RETI = 1'b1;
        bus.BOUNDARY = 1'b1;
        tick();
        check("race_restore_stall", 32'(bus.STALL), 32'd1);
        check("race_restore_taken", 32'(bus.INT_TAKEN), 32'd0);
        tick();
        check("race_run", 32'(bus.STALL), 32'd0);
        check("race_depth0", 32'(bus.DEPTH_CNT), 32'd0);
        tick();
        check("race_save", 32'(bus.STALL), 32'd1);
        tick();
        check("race_taken", 32'(bus.INT_TAKEN), 32'd1);
        tick();
        do_reti();

        // empty pop
        load_flags(1'b1, 1'b1);
        bus.CLI = 1'b1;
        tick();
        do_reti();
        check("ufl_c", 32'(bus.C_FLAG), 32'd1);
        check("ufl_z", 32'(bus.Z_FLAG), 32'd1);
        check("ufl_ie", 32'(bus.IE), 32'd1);
        check("ufl_depth", 32'(bus.DEPTH_CNT), 32'd0);
        check("ufl_err1", 32'(bus.ERR[1]), 32'(ERR_EN));

        // IE gating, entry the cycle after SEI
        bus.CLI = 1'b1;
        tick();
        bus.INTR = 1'b0;
        tick();
        bus.INTR = 1'b1;
        repeat (3) tick();
        check("ie_gate_stall", 32'(bus.STALL), 32'd0);
        do_sei();
        check("ie_qual_stall", 32'(bus.STALL), 32'd0);
        tick();
        check("ie_save", 32'(bus.STALL), 32'd1);
        tick();
        check("ie_taken", 32'(bus.INT_TAKEN), 32'd1);
        tick();

        // asynchronous reset in the middle of SAVE
        do_sei();
        bus.INTR = 1'b0;
        tick();
        bus.INTR = 1'b1;
        tick();
        tick();
        check("arst_in_save", 32'(bus.STALL), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_stall", 32'(bus.STALL), 32'd0);
        check("arst_depth", 32'(bus.DEPTH_CNT), 32'd0);
        check("arst_c", 32'(bus.C_FLAG), 32'd0);
        check("arst_z", 32'(bus.Z_FLAG), 32'd0);
        check("arst_ie", 32'(bus.IE), 32'd0);
        check("arst_err", 32'(bus.ERR), 32'd0);
        tick();
        RST = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.INTR = ~bus.INTR;
            bus.BOUNDARY = ($urandom_range(0, 3) != 0);
            bus.SEI      = ($urandom_range(0, 3) == 0);
            bus.CLI      = ($urandom_range(0, 9) == 0);
            bus.RETI     = ($urandom_range(0, 11) == 0);
            bus.FLG_LD   = ($urandom_range(0, 2) == 0);
            bus.C_IN     = 1'($urandom_range(0, 1));
            bus.Z_IN     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 699) == 0) begin
                #3 RST = 1'b1;
                #2 RST = 1'b0;
            end
            tick();
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
